// File: rtl/eth_tx_scheduler.sv
// Purpose : slices JPEG images from the encoder->Ethernet FIFO into UDP payloads and requests frames.
// Latency : IDLE decision at edge N -> start_send high for one cycle after edge N+1.
// Backpres: waits while tx_busy is high; enforces GAP_CYCLES idle cycles after each tx_done.
//
// Ports:
//   eth_clk, rst        clock, asynchronous active-high reset
//   level               bytes readable on the FIFO read side
//   eoi, img_size       end-of-image pulse and the image byte count
//   tx_busy, tx_done    sender status and end-of-frame pulse
//   start_send          one-cycle frame request
//   pkt_len/seq/img/last header fields, stable from start_send through tx_done
//   err                 sticky protocol error
module eth_tx_scheduler #(
    parameter int PAYLOAD_BYTES = 1024,
    parameter int LEVEL_W       = 13,
    parameter int GAP_CYCLES    = 96
) (
    input  logic               eth_clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level,
    input  logic               eoi,
    input  logic [23:0]        img_size,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               start_send,
    output logic [10:0]        pkt_len,
    output logic [15:0]        pkt_seq,
    output logic [7:0]         pkt_img,
    output logic               pkt_last,
    output logic               err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [23:0]   PAY24    = 24'(PAYLOAD_BYTES);
    localparam logic [10:0]   PAY11    = 11'(PAYLOAD_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SEND, ST_GAP} state_t;

    state_t        r_state;
    logic [23:0]   r_dispatched;
    logic [23:0]   r_size_q;
    logic          r_eoi_pending;
    logic [GW-1:0] r_gap_cnt;

    logic [23:0] w_rem;
    logic [10:0] w_len;
    logic        w_last_fit;
    logic [23:0] w_level;
    logic [23:0] w_disp_next;

    assign w_rem      = r_size_q - r_dispatched;
    assign w_len      = (w_rem < PAY24) ? w_rem[10:0] : PAY11;
    assign w_last_fit = (w_rem <= PAY24);
    assign w_level    = 24'(level);
    // Byte count including a packet being armed on this very edge, so an
    // eoi arriving alongside ARM is checked against the post-ARM total.
    assign w_disp_next = r_dispatched + ((r_state == ST_ARM) ? 24'(pkt_len) : 24'd0);

    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_dispatched  <= '0;
            r_size_q      <= '0;
            r_eoi_pending <= 1'b0;
            r_gap_cnt     <= '0;
            start_send    <= 1'b0;
            pkt_len       <= '0;
            pkt_seq       <= '0;
            pkt_img       <= '0;
            pkt_last      <= 1'b0;
            err           <= 1'b0;
        end else begin
            start_send <= 1'b0;

            // eoi is accepted in any state; a second one while pending is dropped.
            if (eoi) begin
                if (r_eoi_pending) begin
                    err <= 1'b1;
                end else begin
                    r_eoi_pending <= 1'b1;
                    if (img_size < w_disp_next) begin
                        // Image already over-dispatched: close it at what was sent.
                        r_size_q <= w_disp_next;
                        err      <= 1'b1;
                    end else begin
                        r_size_q <= img_size;
                    end
                end
            end

            if (tx_done && (r_state != ST_SEND)) begin
                err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!tx_busy) begin
                        if (r_eoi_pending) begin
                            if (w_rem == 24'd0) begin
                                // Image ended on a packet boundary: close it without a frame.
                                pkt_img       <= pkt_img + 8'd1;
                                r_eoi_pending <= 1'b0;
                                r_dispatched  <= '0;
                            end else if (w_level >= 24'(w_len)) begin
                                pkt_len  <= w_len;
                                pkt_last <= w_last_fit;
                                r_state  <= ST_ARM;
                            end
                        end else if (w_level >= PAY24) begin
                            pkt_len  <= PAY11;
                            pkt_last <= 1'b0;
                            r_state  <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    start_send   <= 1'b1;
                    r_dispatched <= r_dispatched + 24'(pkt_len);
                    r_state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_done) begin
                        pkt_seq   <= pkt_seq + 16'd1;
                        r_gap_cnt <= '0;
                        if (pkt_last) begin
                            pkt_img       <= pkt_img + 8'd1;
                            r_eoi_pending <= 1'b0;
                            r_dispatched  <= '0;
                        end
                        r_state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
module tb_eth_tx_scheduler;

    logic        eth_clk = 1'b0;
    logic        rst;
    logic [12:0] level;
    logic        eoi;
    logic [23:0] img_size;
    logic        tx_busy;
    logic        tx_done;
    logic        start_send;
    logic [10:0] pkt_len;
    logic [15:0] pkt_seq;
    logic [7:0]  pkt_img;
    logic        pkt_last;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc;
    int nst;

    always #5 eth_clk = ~eth_clk;

    eth_tx_scheduler #(
        .PAYLOAD_BYTES(1024),
        .LEVEL_W      (13),
        .GAP_CYCLES   (4)
    ) dut (
        .eth_clk   (eth_clk),
        .rst       (rst),
        .level     (level),
        .eoi       (eoi),
        .img_size  (img_size),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .start_send(start_send),
        .pkt_len   (pkt_len),
        .pkt_seq   (pkt_seq),
        .pkt_img   (pkt_img),
        .pkt_last  (pkt_last),
        .err       (err)
    );

    task automatic tick();
        @(posedge eth_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_eoi(input logic [23:0] sz);
        eoi      = 1'b1;
        img_size = sz;
        tick();
        eoi      = 1'b0;
    endtask

    // Ticks until start_send is seen; returns ticks taken. Timeout counts as a failure.
    task automatic wait_start(input string tag, output int c);
        c = 0;
        while (start_send !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        total++;
        assert (start_send === 1'b1) else begin
            bad++;
            $error("FAIL %s start_send timeout observed=%b expected=1", tag, start_send);
        end
    endtask

    task automatic count_starts(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (start_send === 1'b1) c++;
        end
    endtask

    initial begin
        rst = 1'b1; level = '0; eoi = 1'b0; img_size = '0; tx_busy = 1'b0; tx_done = 1'b0;
        ticks(3);
        chk("rst_start", start_send, 0);
        chk("rst_len",   pkt_len,    0);
        chk("rst_seq",   pkt_seq,    0);
        chk("rst_img",   pkt_img,    0);
        chk("rst_last",  pkt_last,   0);
        chk("rst_err",   err,        0);
        rst = 1'b0;

        // Below a full payload with no eoi: nothing is sent.
        level = 13'd500;
        ticks(3);
        chk("partial_no_start", start_send, 0);

        // Full packet and start latency.
        level = 13'd1024;
        tick();
        chk("lat_edge1", start_send, 0);
        tick();
        chk("lat_edge2", start_send, 1);
        chk("p0_len",  pkt_len,  1024);
        chk("p0_last", pkt_last, 0);
        chk("p0_seq",  pkt_seq,  0);
        chk("p0_img",  pkt_img,  0);
        level = 13'd0;
        tick();
        chk("start_one_cycle", start_send, 0);
        ticks(3);
        pulse_done();
        chk("seq_after_done", pkt_seq, 1);
        chk("len_stable", pkt_len, 1024);

        // Back-to-back spacing with data ready: GAP_CYCLES+2.
        level = 13'd1024;
        wait_start("p1", cyc);
        chk("p1_spacing", cyc, 6);
        chk("p1_seq", pkt_seq, 1);
        chk("p1_len", pkt_len, 1024);
        level = 13'd0;
        tick();
        pulse_done();
        chk("p1_seq_after", pkt_seq, 2);

        // eoi exactly at dispatched count (2048): close without a frame.
        pulse_eoi(24'd2048);
        count_starts(8, nst);
        chk("close0_no_start", nst, 0);
        chk("close0_img", pkt_img, 1);
        chk("close0_err", err, 0);

        // Image of 2500 bytes: 1024, 1024, 452 (last).
        pulse_eoi(24'd2500);
        level = 13'd2500;
        wait_start("img_a", cyc);
        chk("img_a_len", pkt_len, 1024);
        chk("img_a_last", pkt_last, 0);
        chk("img_a_seq", pkt_seq, 2);
        level = 13'd1476;
        tick();
        pulse_done();
        chk("img_a_img", pkt_img, 1);
        wait_start("img_b", cyc);
        chk("img_b_len", pkt_len, 1024);
        chk("img_b_last", pkt_last, 0);
        chk("img_b_seq", pkt_seq, 3);
        level = 13'd452;
        tick();
        pulse_done();
        wait_start("img_c", cyc);
        chk("img_c_len", pkt_len, 452);
        chk("img_c_last", pkt_last, 1);
        chk("img_c_seq", pkt_seq, 4);
        chk("img_c_img", pkt_img, 1);
        level = 13'd0;
        tick();
        pulse_done();
        chk("img_c_img_after", pkt_img, 2);
        chk("img_c_seq_after", pkt_seq, 5);

        // Exact multiple: 2048 -> two packets, no zero-length third.
        pulse_eoi(24'd2048);
        level = 13'd2048;
        wait_start("ex_a", cyc);
        chk("ex_a_len", pkt_len, 1024);
        chk("ex_a_last", pkt_last, 0);
        level = 13'd1024;
        tick();
        pulse_done();
        wait_start("ex_b", cyc);
        chk("ex_b_len", pkt_len, 1024);
        chk("ex_b_last", pkt_last, 1);
        chk("ex_b_seq", pkt_seq, 6);
        level = 13'd1023;
        tick();
        pulse_done();
        count_starts(10, nst);
        chk("ex_no_extra", nst, 0);
        chk("ex_img", pkt_img, 3);
        chk("ex_seq", pkt_seq, 7);

        // Gap and busy: sender stays busy well after the gap.
        level = 13'd1024;
        wait_start("busy_a", cyc);
        chk("busy_a_seq", pkt_seq, 7);
        tx_busy = 1'b1;
        ticks(2);
        pulse_done();
        count_starts(15, nst);
        chk("busy_hold", nst, 0);
        tx_busy = 1'b0;
        wait_start("busy_b", cyc);
        chk("busy_release_lat", cyc, 2);
        chk("busy_b_seq", pkt_seq, 8);
        level = 13'd0;
        tick();
        pulse_done();
        chk("busy_b_seq_after", pkt_seq, 9);
        chk("err_clean", err, 0);

        // Second eoi while pending: flagged and ignored (size 3000 kept, 952 left).
        pulse_eoi(24'd3000);
        chk("eoi1_err", err, 0);
        tick();
        pulse_eoi(24'd100);
        chk("eoi2_err", err, 1);
        count_starts(8, nst);
        chk("eoi2_no_start", nst, 0);
        chk("eoi2_img", pkt_img, 3);
        level = 13'd952;
        wait_start("rem952", cyc);
        chk("rem952_len", pkt_len, 952);
        chk("rem952_last", pkt_last, 1);
        chk("rem952_seq", pkt_seq, 9);

        // Reset while in SEND: outputs clear without waiting for a clock.
        ticks(2);
        rst = 1'b1;
        #1;
        chk("mrst_start", start_send, 0);
        chk("mrst_len",   pkt_len,    0);
        chk("mrst_seq",   pkt_seq,    0);
        chk("mrst_img",   pkt_img,    0);
        chk("mrst_last",  pkt_last,   0);
        chk("mrst_err",   err,        0);
        level = 13'd0;
        tick();
        rst = 1'b0;

        // tx_done in IDLE: flagged, no state change.
        ticks(2);
        pulse_done();
        chk("stray_done_err", err, 1);
        chk("stray_done_seq", pkt_seq, 0);
        count_starts(3, nst);
        chk("stray_done_no_start", nst, 0);
        level = 13'd1024;
        wait_start("post_rst", cyc);
        chk("post_rst_seq", pkt_seq, 0);
        chk("post_rst_len", pkt_len, 1024);
        chk("post_rst_img", pkt_img, 0);
        level = 13'd0;
        tick();
        pulse_done();
        chk("post_rst_seq_after", pkt_seq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
